cnt_seq_arbiter: RTL and testbench

- Shares one programmable step-counter datapath (load value, add step each cycle, wrap modulo 2^CNT_W) among NUM_REQ requesters.
- Each requester asks for a run defined by start value, step and length.
- A round-robin arbiter picks one request and an FSM sequences the counter through that run.
- The FSM then signals completion to the winning requester.

---
 rtl/cnt_seq_pkg.sv | 15 +
 rtl/cnt_seq_arbiter_rr_arbiter.sv | 33 +++
 rtl/cnt_seq_arbiter.sv | 141 ++++++++++++++
 tb/tb_cnt_seq_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cnt_seq_pkg.sv
// Shared types and default widths for the counter-sequencer arbiter.
package cnt_seq_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_ID_W    = $clog2(DEF_NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cnt_seq_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr_i with wrap; grant only while advance_i.
module rr_arbiter
  import cnt_seq_pkg::*;
#(
  parameter int N   = DEF_NUM_REQ,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  input  logic           advance_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] id_o
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDW'((int'(ptr_i) + i) % N);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = advance_i;
        id_o       = idx;
      end
    end
  end

endmodule

// File: rtl/cnt_seq_arbiter.sv
// Shared step-counter sequenced among round-robin requesters.
// Optional CNT_SEQ_STALL_EN adds cnt_ready_i backpressure on the count stream.
module cnt_seq_arbiter
  import cnt_seq_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*CNT_W-1:0]   start_i,
  input  logic [NUM_REQ*CNT_W-1:0]   step_i,
  input  logic [NUM_REQ*LEN_W-1:0]   len_i,
`ifdef CNT_SEQ_STALL_EN
  input  logic                       cnt_ready_i,
`endif
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       cnt_valid_o,
  output logic [CNT_W-1:0]           cnt_o,
  output logic [$clog2(NUM_REQ)-1:0] cnt_id_o,
  output logic                       done_o,
  output logic [$clog2(NUM_REQ)-1:0] done_id_o
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [LEN_W-1:0] rem_q, rem_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_id;
  logic               arb_adv;
  logic               ready;
  logic [CNT_W-1:0]   win_start, win_step;
  logic [LEN_W-1:0]   win_len;

`ifdef CNT_SEQ_STALL_EN
  assign ready = cnt_ready_i;
`else
  assign ready = 1'b1;
`endif

  // Grant is only offered while idle and never while reset is held.
  assign arb_adv = (state_q == ST_IDLE) && !reset;
  assign gnt_o   = arb_gnt;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_arb (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .advance_i (arb_adv),
    .gnt_o     (arb_gnt),
    .id_o      (arb_id)
  );

  always_comb begin
    win_start = '0;
    win_step  = '0;
    win_len   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_id == ID_W'(k)) begin
        win_start = start_i[k*CNT_W +: CNT_W];
        win_step  = step_i[k*CNT_W +: CNT_W];
        win_len   = len_i[k*LEN_W +: LEN_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          id_d   = arb_id;
          step_d = win_step;
          rem_d  = win_len;
          ptr_d  = (arb_id == ID_W'(NUM_REQ - 1)) ? '0 : arb_id + 1'b1;
          // A zero-length run leaves cnt_o untouched and goes straight to DONE.
          if (win_len != '0) begin
            cnt_d   = win_start;
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (ready) begin
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + step_q;
            rem_d = rem_q - 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_valid_o = (state_q == ST_RUN);
    cnt_o       = cnt_q;
    cnt_id_o    = id_q;
    done_o      = (state_q == ST_DONE);
    done_id_o   = (state_q == ST_DONE) ? id_q : '0;
  end

endmodule

// File: tb/tb_cnt_seq_arbiter.sv
// Directed bench for cnt_seq_arbiter with hand-computed expected values.
module tb_cnt_seq_arbiter;

  localparam int NR = 4;
  localparam int CW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic [NR*CW-1:0] start, step;
  logic [NR*LW-1:0] len;
  logic          rdy;
  logic [NR-1:0] gnt;
  logic          cnt_valid;
  logic [CW-1:0] cnt;
  logic [1:0]    cnt_id;
  logic          done;
  logic [1:0]    done_id;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cnt_seq_arbiter #(.NUM_REQ(NR), .CNT_W(CW), .LEN_W(LW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req),
    .start_i     (start),
    .step_i      (step),
    .len_i       (len),
`ifdef CNT_SEQ_STALL_EN
    .cnt_ready_i (rdy),
`endif
    .gnt_o       (gnt),
    .cnt_valid_o (cnt_valid),
    .cnt_o       (cnt),
    .cnt_id_o    (cnt_id),
    .done_o      (done),
    .done_id_o   (done_id)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int k, input logic [7:0] st, input logic [7:0] sp,
                            input logic [3:0] ln);
    start[k*CW +: CW] = st;
    step[k*CW +: CW]  = sp;
    len[k*LW +: LW]   = ln;
  endtask

  // Grant in the current idle cycle, then ln valid counts, then one done cycle.
  task automatic run_one(input int k, input logic [3:0] reqv, input logic [3:0] req_after,
                         input logic [7:0] st, input logic [7:0] sp, input logic [3:0] ln);
    logic [7:0] exp;
    logic [7:0] last;
    set_fields(k, st, sp, ln);
    req = reqv;
    #1;
    check_eq("gnt", 32'(gnt), 32'(1) << k);
    step_clk();
    req  = req_after;
    exp  = st;
    last = st;
    for (int i = 0; i < int'(ln); i++) begin
      #1;
      check_eq("cnt_valid", 32'(cnt_valid), 32'd1);
      check_eq("cnt", 32'(cnt), 32'(exp));
      check_eq("cnt_id", 32'(cnt_id), 32'(k));
      check_eq("gnt_run", 32'(gnt), 32'd0);
      last = exp;
      exp  = exp + sp;
      step_clk();
    end
    #1;
    check_eq("done", 32'(done), 32'd1);
    check_eq("done_id", 32'(done_id), 32'(k));
    check_eq("valid_in_done", 32'(cnt_valid), 32'd0);
    if (ln != 4'd0) check_eq("cnt_hold", 32'(cnt), 32'(last));
    step_clk();
    check_eq("done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    req   = '1;
    start = '0;
    step  = '0;
    len   = '0;
    rdy   = 1'b1;
    step_clk();
    step_clk();
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_valid", 32'(cnt_valid), 32'd0);
    check_eq("rst_cnt", 32'(cnt), 32'd0);
    check_eq("rst_cnt_id", 32'(cnt_id), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_done_id", 32'(done_id), 32'd0);
    reset = 1'b0;
    req   = '0;
    step_clk();

    // Requester 0: 01,03,05,07
    run_one(0, 4'b0001, 4'b0000, 8'h01, 8'h02, 4'd4);
    // Requester 2 wraps: FD,FF,01
    run_one(2, 4'b0100, 4'b0000, 8'hFD, 8'h02, 4'd3);
    // Zero-length run: grant then done, never valid
    run_one(1, 4'b0010, 4'b0000, 8'h55, 8'h01, 4'd0);

    // Reset during the second valid count of a len=5 run
    set_fields(2, 8'h30, 8'h01, 4'd5);
    req = 4'b0100;
    #1;
    check_eq("gnt_abort", 32'(gnt), 32'b0100);
    step_clk();
    req = 4'b0000;
    #1;
    check_eq("abort_cnt0", 32'(cnt), 32'h30);
    step_clk();
    #1;
    check_eq("abort_cnt1", 32'(cnt), 32'h31);
    reset = 1'b1;
    req   = 4'b1000;
    #1;
    check_eq("gnt_in_reset", 32'(gnt), 32'd0);
    step_clk();
    reset = 1'b0;
    req   = 4'b0000;
    #1;
    check_eq("abort_valid", 32'(cnt_valid), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_cnt", 32'(cnt), 32'd0);
    // Pointer is back at 0, so 0 beats 3 when both ask
    req = 4'b1001;
    #1;
    check_eq("ptr_reset", 32'(gnt), 32'b0001);
    run_one(3, 4'b1000, 4'b0000, 8'h40, 8'h01, 4'd1);

    // All requesting, len=1 each: rotation 0,1,2,3,0
    for (int k = 0; k < NR; k++) set_fields(k, 8'(8'h20 + k), 8'h01, 4'd1);
    for (int j = 0; j < 5; j++)
      run_one(order[j], 4'b1111, 4'b1111, 8'(8'h20 + order[j]), 8'h01, 4'd1);
    req = 4'b0000;
    step_clk();

    // Maximum length run: 15 counts of 0xF0 step 1, last count 0xFE
    run_one(1, 4'b0010, 4'b0000, 8'hF0, 8'h01, 4'd15);
    // step=0 keeps the count constant
    run_one(2, 4'b0100, 4'b0000, 8'h77, 8'h00, 4'd3);

`ifdef CNT_SEQ_STALL_EN
    set_fields(0, 8'h10, 8'h01, 4'd3);
    req = 4'b0001;
    #1;
    check_eq("stall_gnt", 32'(gnt), 32'b0001);
    step_clk();
    req = 4'b0000;
    rdy = 1'b0;
    #1;
    check_eq("stall_c0", 32'(cnt), 32'h10);
    check_eq("stall_v0", 32'(cnt_valid), 32'd1);
    step_clk();
    #1;
    check_eq("stall_c1", 32'(cnt), 32'h10);
    check_eq("stall_v1", 32'(cnt_valid), 32'd1);
    step_clk();
    rdy = 1'b1;
    #1;
    check_eq("stall_c2", 32'(cnt), 32'h10);
    step_clk();
    #1;
    check_eq("stall_c3", 32'(cnt), 32'h11);
    step_clk();
    #1;
    check_eq("stall_c4", 32'(cnt), 32'h12);
    check_eq("stall_nodone", 32'(done), 32'd0);
    step_clk();
    #1;
    check_eq("stall_done", 32'(done), 32'd1);
    check_eq("stall_done_id", 32'(done_id), 32'd0);
    step_clk();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
